// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC core and its gain-compensation stage.
// K_INV is round(0.607252935 * 2^32), the reciprocal of the CORDIC processing gain.
package cordic_pkg;

    localparam int CORDIC_WIDTH = 32;
    localparam logic [31:0] CORDIC_K_INV = 32'h9B74EDA8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } gc_state_t;

endpackage

// File: rtl/cordic_serial_mul.sv
// Bit-serial signed x unsigned multiplier, round-half-up, one multiplier bit per step.
// Latency: W steps after i_start; o_result already includes the bit processed this cycle.
module cordic_serial_mul #(
    parameter int W  = 32,
    parameter int CW = $clog2(W)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_start,
    input  logic          i_step,
    input  logic          i_k_bit,
    input  logic [CW-1:0] i_idx,
    input  logic [W-1:0]  i_v,
    output logic          o_done,
    output logic [W-1:0]  o_result
);

    localparam int ACC_W = 2 * W + 1;
    localparam logic [ACC_W-1:0] RND = {{(W + 1){1'b0}}, 1'b1, {(W - 1){1'b0}}};

    logic [W-1:0]     r_v;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_v_ext;
    logic [ACC_W-1:0] w_addend;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [ACC_W-1:0] w_rounded;
    logic             w_unused;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v   <= '0;
            r_acc <= '0;
        end else if (i_start) begin
            r_v   <= i_v;
            r_acc <= '0;
        end else if (i_step) begin
            r_acc <= w_acc_nxt;
        end
    end

    // Two's-complement wrap in the wide accumulator makes a plain shifted add correct for negative v.
    assign w_v_ext   = {{(W + 1){r_v[W-1]}}, r_v};
    assign w_addend  = i_k_bit ? (w_v_ext << i_idx) : '0;
    assign w_acc_nxt = r_acc + w_addend;
    assign w_rounded = w_acc_nxt + RND;

    // |v * K_INV| < 2^(2W-1), so the rounded quotient always fits in W signed bits.
    assign o_result = w_rounded[2*W-1:W];
    assign o_done   = i_step && (i_idx == CW'(W - 1));
    assign w_unused = ^{w_rounded[ACC_W-1], w_rounded[W-1:0]};

endmodule

// File: rtl/cordic_gain_comp.sv
// Removes the CORDIC gain from x and y using two bit-serial multipliers; angle and mode pass through.
// Latency: out_valid rises WIDTH edges after accept; one word in flight, in_ready only in IDLE.
module cordic_gain_comp
    import cordic_pkg::*;
#(
    parameter int               WIDTH = CORDIC_WIDTH,
    parameter logic [WIDTH-1:0] K_INV = CORDIC_K_INV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic [WIDTH-1:0] in_angle,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_mode,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_y,
    output logic [WIDTH-1:0] out_angle
);

    localparam int CW = $clog2(WIDTH);

    gc_state_t        r_state;
    gc_state_t        w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic             r_mode_lat;
    logic [WIDTH-1:0] r_angle_lat;
    logic             r_out_mode;
    logic [WIDTH-1:0] r_out_x;
    logic [WIDTH-1:0] r_out_y;
    logic [WIDTH-1:0] r_out_angle;
    logic             w_start;
    logic             w_step;
    logic             w_done;
    logic             w_done_x;
    logic             w_done_y;
    logic [WIDTH-1:0] w_res_x;
    logic [WIDTH-1:0] w_res_y;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_nxt = MUL;
            MUL:     if (w_done) w_state_nxt = HOLD;
            HOLD:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == HOLD);
        w_start   = (r_state == IDLE) && in_valid;
        w_step    = (r_state == MUL);
    end

    assign w_done = w_done_x & w_done_y;

    // Angle/mode are staged so every output field changes together when the result lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_mode_lat  <= 1'b0;
            r_angle_lat <= '0;
            r_out_mode  <= 1'b0;
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_out_angle <= '0;
        end else begin
            if (w_start) begin
                r_cnt       <= '0;
                r_mode_lat  <= in_mode;
                r_angle_lat <= in_angle;
            end else if (w_step) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_step && w_done) begin
                r_out_x     <= w_res_x;
                r_out_y     <= w_res_y;
                r_out_angle <= r_angle_lat;
                r_out_mode  <= r_mode_lat;
            end
        end
    end

    cordic_serial_mul #(.W(WIDTH), .CW(CW)) u_mul_x (
        .clk      (clk),
        .reset    (reset),
        .i_start  (w_start),
        .i_step   (w_step),
        .i_k_bit  (K_INV[r_cnt]),
        .i_idx    (r_cnt),
        .i_v      (in_x),
        .o_done   (w_done_x),
        .o_result (w_res_x)
    );

    cordic_serial_mul #(.W(WIDTH), .CW(CW)) u_mul_y (
        .clk      (clk),
        .reset    (reset),
        .i_start  (w_start),
        .i_step   (w_step),
        .i_k_bit  (K_INV[r_cnt]),
        .i_idx    (r_cnt),
        .i_v      (in_y),
        .o_done   (w_done_y),
        .o_result (w_res_y)
    );

    assign out_mode  = r_out_mode;
    assign out_x     = r_out_x;
    assign out_y     = r_out_y;
    assign out_angle = r_out_angle;

endmodule

// File: tb/tb_cordic_gain_comp.sv
// Directed and randomized bench for cordic_gain_comp with a 64-bit multiply reference.
module tb_cordic_gain_comp;

    localparam logic [31:0] K_REF = 32'h9B74EDA8;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_mode;
    logic [31:0] in_x;
    logic [31:0] in_y;
    logic [31:0] in_angle;
    logic        out_valid;
    logic        out_ready;
    logic        out_mode;
    logic [31:0] out_x;
    logic [31:0] out_y;
    logic [31:0] out_angle;

    int checks = 0;
    int errors = 0;

    cordic_gain_comp dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_angle  (in_angle),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mode  (out_mode),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_angle (out_angle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_comp(input logic [31:0] v);
        longint p;
        p = longint'($signed(v)) * longint'({32'h0, K_REF});
        p = (p + 64'sd2147483648) >>> 32;
        return p[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one word, measure latency, check all fields, then complete the handshake.
    task automatic run_txn(input logic [31:0] x, input logic [31:0] y, input logic [31:0] a,
                           input logic m, input logic [31:0] ex, input logic [31:0] ey,
                           input int stall, input string tag);
        int  lat;
        bit  seen;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s in_ready_before: got %b want 1", tag, in_ready);
        end
        in_x = x; in_y = y; in_angle = a; in_mode = m; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        lat = 0;
        seen = 0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            lat = k;
            if (out_valid === 1'b1) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen || lat != 32) begin
            errors++;
            $display("FAIL %s latency: got %0d (seen=%0d) want 32", tag, lat, seen);
        end
        checks++;
        if (out_x !== ex) begin
            errors++;
            $display("FAIL %s out_x: got %0d want %0d", tag, $signed(out_x), $signed(ex));
        end
        checks++;
        if (out_y !== ey) begin
            errors++;
            $display("FAIL %s out_y: got %0d want %0d", tag, $signed(out_y), $signed(ey));
        end
        checks++;
        if (out_angle !== a || out_mode !== m) begin
            errors++;
            $display("FAIL %s angle/mode: got %h/%b want %h/%b", tag, out_angle, out_mode, a, m);
        end
        repeat (stall) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s release: got valid=%b ready=%b want 0/1", tag, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0; in_mode = 1'b0; in_x = '0; in_y = '0; in_angle = '0; out_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: got ready=%b valid=%b want 1/0", in_ready, out_valid);
        end
        checks++;
        if (out_x !== 32'd0 || out_y !== 32'd0 || out_angle !== 32'd0 || out_mode !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: got %h %h %h %b want zeros", out_x, out_y, out_angle, out_mode);
        end
    endtask

    task automatic test_basic();
        run_txn(32'h40000000, 32'h0, 32'h40000000, 1'b0, 32'd652032874, 32'd0, 0, "pos_x");
        run_txn(32'hC0000000, 32'h1, 32'h0, 1'b0, -32'sd652032874, 32'd1, 0, "neg_x");
        run_txn(32'h0, 32'hFFFFFFFF, 32'h0, 1'b0, 32'd0, 32'hFFFFFFFF, 0, "neg_one");
    endtask

    // (2^31-1)*K/2^32 + 0.5 = 1304065747.89, which floors to ...747.
    task automatic test_extremes();
        run_txn(32'h80000000, 32'h7FFFFFFF, 32'h80000000, 1'b1,
                -32'sd1304065748, 32'd1304065747, 0, "extremes");
    endtask

    task automatic test_hold_stall();
        int bad;
        in_x = 32'h40000000; in_y = 32'hC0000000; in_angle = 32'h12345678; in_mode = 1'b1;
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (32) tick();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_entry: got valid=%b want 1", out_valid);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_x = 32'h7 + i; in_y = 32'h9 + i; in_angle = 32'hDEAD0000 + i; in_mode = 1'b0;
            tick();
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_x !== 32'd652032874 ||
                out_y !== -32'sd652032874 || out_angle !== 32'h12345678 || out_mode !== 1'b1)
                bad++;
        end
        in_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_stable: got %0d unstable cycles want 0", bad);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_x !== 32'd652032874 ||
            out_angle !== 32'h12345678) begin
            errors++;
            $display("FAIL hold_release: got ready=%b valid=%b x=%0d want 1/0/652032874",
                     in_ready, out_valid, $signed(out_x));
        end
        run_txn(32'h0, 32'hFFFFFFFF, 32'h5, 1'b0, 32'd0, 32'hFFFFFFFF, 0, "after_hold");
    endtask

    task automatic test_reset_mid();
        in_x = 32'h40000000; in_y = 32'h40000000; in_angle = 32'h11111111; in_mode = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (15) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_hs: got ready=%b valid=%b want 1/0", in_ready, out_valid);
        end
        checks++;
        if (out_x !== 32'd0 || out_y !== 32'd0 || out_angle !== 32'd0 || out_mode !== 1'b0) begin
            errors++;
            $display("FAIL midreset_out: got %h %h %h %b want zeros", out_x, out_y, out_angle, out_mode);
        end
        run_txn(32'hC0000000, 32'h40000000, 32'h22222222, 1'b0,
                -32'sd652032874, 32'd652032874, 1, "after_reset");
    endtask

    task automatic test_random();
        logic [31:0] x, y, a;
        logic        m;
        for (int i = 0; i < 1000; i++) begin
            x = $urandom;
            y = (i % 4 == 0) ? 32'($signed($urandom_range(0, 64)) - 32) : $urandom;
            a = $urandom;
            m = 1'($urandom_range(0, 1));
            run_txn(x, y, a, m, ref_comp(x), ref_comp(y), $urandom_range(0, 3), "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_hold_stall();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
